// File: rtl/fetch_buf.sv
// Instruction-fetch front end: registered PC, credit-limited imem request port,
// in-order fetch queue toward decode, with redirect flush and stale-response dropping.
module fetch_buf #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [WIDTH-1:0] imem_req_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
    input  logic             redirect_valid_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             fetch_valid_o,
    input  logic             fetch_ready_i,
    output logic [WIDTH-1:0] fetch_pc_o,
    output logic [WIDTH-1:0] fetch_pre_pc_o,
    output logic [31:0]      fetch_instr_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_pc;
    logic [CW-1:0]    r_inflight;
    logic [CW-1:0]    r_drop;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_tag_wr;
    logic [PW-1:0]    r_tag_rd;
    logic [WIDTH-1:0] r_q_pc    [DEPTH];
    logic [31:0]      r_q_instr [DEPTH];
    logic [WIDTH-1:0] r_tag     [DEPTH];

    logic [CW:0] w_credit;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_rsp_keep;
    logic        w_deq;

    // Outstanding requests plus queued entries may never exceed DEPTH, so every
    // response that is kept always finds a free queue slot.
    assign w_credit    = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req_valid = !redirect_valid_i && (w_credit < (CW + 1)'(DEPTH));
    assign w_req_fire  = w_req_valid && imem_req_ready_i;
    assign w_rsp_keep  = imem_rsp_valid_i && !redirect_valid_i && (r_drop == '0);
    assign w_deq       = (r_count != '0) && fetch_ready_i && !redirect_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
        end else begin
            // The tag FIFO tracks every request/response pair, including dropped ones.
            if (w_req_fire)       r_tag_wr <= r_tag_wr + PW'(1);
            if (imem_rsp_valid_i) r_tag_rd <= r_tag_rd + PW'(1);
            r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid_i);
            if (redirect_valid_i) begin
                r_pc     <= {redirect_pc_i[WIDTH-1:2], 2'b00};
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
                r_drop   <= r_inflight - CW'(imem_rsp_valid_i);
            end else begin
                if (w_req_fire) r_pc <= r_pc + WIDTH'(4);
                if (imem_rsp_valid_i && (r_drop != '0)) r_drop <= r_drop - CW'(1);
                if (w_rsp_keep) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_deq)      r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_rsp_keep) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) r_tag[r_tag_wr] <= r_pc;
        if (w_rsp_keep) begin
            r_q_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
            r_q_instr[r_wr_ptr] <= imem_rsp_data_i;
        end
    end

    assign imem_req_valid_o = w_req_valid;
    assign imem_req_addr_o  = r_pc;
    assign fetch_valid_o    = (r_count != '0);
    assign fetch_pc_o       = r_q_pc[r_rd_ptr];
    assign fetch_pre_pc_o   = r_q_pc[r_rd_ptr] + WIDTH'(4);
    assign fetch_instr_o    = r_q_instr[r_rd_ptr];

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid_i |-> (r_inflight != '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        w_rsp_keep |-> (r_count != CW'(DEPTH)));
endmodule
